tile_diff_classifier: RTL

Parametrised successor to the tile absolute-difference stage of the RGB lossless compressor. It accepts one TILE_SIZE x TILE_SIZE tile of PIX_W-bit samples through a valid/ready handshake and processes one tile row per cycle. For each sample it produces a horizontal (row) and a vertical (col) absolute difference, each with a 3-bit class flag. It also sums an estimated bit cost per direction and reports the cheaper direction. The packer/encoder stage downstream consumes the results.

---
 rtl/tile_diff_classifier.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tile_diff_classifier.sv
// Tile absolute-difference classifier: takes one TILE_SIZE x TILE_SIZE tile,
// walks it one row per cycle, and produces per-sample row/col abs diffs, class
// flags and summed bit costs. It also reports which direction is cheaper.
//
// state | meaning
// IDLE  | ready for a new tile
// RUN   | processing row row_cnt_q of the buffered tile
// DONE  | results held; o_valid raised after one settle cycle
module tile_diff_classifier #(
    parameter int TILE_SIZE = 8,
    parameter int PIX_W     = 8,
    parameter int T1        = 2,
    parameter int T2        = 4,
    parameter int COST_W    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_valid,
    output logic                                  i_ready,
    input  logic [TILE_SIZE*TILE_SIZE*PIX_W-1:0]  i_data,
    output logic                                  o_valid,
    input  logic                                  o_ready,
    output logic [TILE_SIZE*TILE_SIZE*PIX_W-1:0]  o_row_abs,
    output logic [TILE_SIZE*TILE_SIZE*PIX_W-1:0]  o_col_abs,
    output logic [TILE_SIZE*TILE_SIZE*3-1:0]      o_row_flag,
    output logic [TILE_SIZE*TILE_SIZE*3-1:0]      o_col_flag,
    output logic [COST_W-1:0]                     o_row_cost,
    output logic [COST_W-1:0]                     o_col_cost,
    output logic                                  o_sel_col
);
    localparam int NPIX  = TILE_SIZE * TILE_SIZE;
    localparam int ROW_W = TILE_SIZE * PIX_W;
    localparam int CNT_W = $clog2(TILE_SIZE);
    // A whole row's cost is at most 16*12, so 8 guard bits cover any row sum.
    localparam int SUM_W = COST_W + 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        row_cnt_q;
    logic [NPIX*PIX_W-1:0]   tile_q, row_abs_q, col_abs_q;
    logic [NPIX*3-1:0]       row_flag_q, col_flag_q;
    logic [COST_W-1:0]       row_cost_q, col_cost_q;
    logic                    sel_col_q, valid_q;

    logic [ROW_W-1:0]        row_abs_n, col_abs_n;
    logic [TILE_SIZE*3-1:0]  row_flag_n, col_flag_n;
    logic [SUM_W-1:0]        row_sum_n, col_sum_n;
    logic                    accept, last_row;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] cur, input logic [PIX_W-1:0] pred);
        return (cur >= pred) ? (cur - pred) : (pred - cur);
    endfunction

    function automatic logic [2:0] classify(input logic [PIX_W-1:0] cur, input logic [PIX_W-1:0] pred);
        logic [PIX_W-1:0] mag;
        logic             neg;
        neg = (cur < pred);
        mag = abs_diff(cur, pred);
        if (mag == '0)                 return 3'd0;
        if (mag[PIX_W-1:T1] == '0)     return neg ? 3'd2 : 3'd1;
        if (mag[PIX_W-1:T2] == '0)     return neg ? 3'd4 : 3'd3;
        return neg ? 3'd6 : 3'd5;
    endfunction

    function automatic logic [SUM_W-1:0] flag_cost(input logic [2:0] f);
        case (f)
            3'd0:       return '0;
            3'd1, 3'd2: return SUM_W'(T1);
            3'd3, 3'd4: return SUM_W'(T2);
            default:    return SUM_W'(PIX_W);
        endcase
    endfunction

    function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] acc, input logic [SUM_W-1:0] add);
        logic [SUM_W-1:0] tot;
        tot = SUM_W'(acc) + add;
        return (|tot[SUM_W-1:COST_W]) ? '1 : tot[COST_W-1:0];
    endfunction

    assign i_ready    = (state_q == IDLE);
    assign accept     = i_valid & i_ready;
    assign last_row   = (row_cnt_q == CNT_W'(TILE_SIZE - 1));
    assign o_valid    = valid_q;
    assign o_row_abs  = row_abs_q;
    assign o_col_abs  = col_abs_q;
    assign o_row_flag = row_flag_q;
    assign o_col_flag = col_flag_q;
    assign o_row_cost = row_cost_q;
    assign o_col_cost = col_cost_q;
    assign o_sel_col  = sel_col_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_row) state_d = DONE;
            DONE:    if (valid_q && o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-column diffs, flags and cost sums for the row currently addressed.
    always_comb begin
        int               r;
        logic [PIX_W-1:0] cur, rpred, cpred;
        logic [2:0]       rf, cf;
        row_abs_n  = '0;
        col_abs_n  = '0;
        row_flag_n = '0;
        col_flag_n = '0;
        row_sum_n  = '0;
        col_sum_n  = '0;
        r          = int'(row_cnt_q);
        for (int c = 0; c < TILE_SIZE; c++) begin
            cur   = tile_q[(r*TILE_SIZE + c)*PIX_W +: PIX_W];
            rpred = '0;
            cpred = '0;
            if (c > 0)      rpred = tile_q[(r*TILE_SIZE + c - 1)*PIX_W +: PIX_W];
            else if (r > 0) rpred = tile_q[((r - 1)*TILE_SIZE)*PIX_W +: PIX_W];
            if (r > 0)      cpred = tile_q[((r - 1)*TILE_SIZE + c)*PIX_W +: PIX_W];
            else if (c > 0) cpred = tile_q[(c - 1)*PIX_W +: PIX_W];
            if (r == 0 && c == 0) begin
                // Origin sample has no predictor: raw value is sent verbatim.
                rf = 3'd7;
                cf = 3'd7;
            end else begin
                rf = classify(cur, rpred);
                cf = classify(cur, cpred);
            end
            row_abs_n[c*PIX_W +: PIX_W] = abs_diff(cur, rpred);
            col_abs_n[c*PIX_W +: PIX_W] = abs_diff(cur, cpred);
            row_flag_n[c*3 +: 3]        = rf;
            col_flag_n[c*3 +: 3]        = cf;
            row_sum_n                   = row_sum_n + flag_cost(rf);
            col_sum_n                   = col_sum_n + flag_cost(cf);
        end
    end

    // Tile buffer, result registers and cost accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q     <= '0;
            row_cnt_q  <= '0;
            row_abs_q  <= '0;
            col_abs_q  <= '0;
            row_flag_q <= '0;
            col_flag_q <= '0;
            row_cost_q <= '0;
            col_cost_q <= '0;
            sel_col_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tile_q     <= i_data;
                        row_cnt_q  <= '0;
                        row_abs_q  <= '0;
                        col_abs_q  <= '0;
                        row_flag_q <= '0;
                        col_flag_q <= '0;
                        row_cost_q <= '0;
                        col_cost_q <= '0;
                        sel_col_q  <= 1'b0;
                        valid_q    <= 1'b0;
                    end
                end
                RUN: begin
                    row_abs_q[int'(row_cnt_q)*ROW_W +: ROW_W]           <= row_abs_n;
                    col_abs_q[int'(row_cnt_q)*ROW_W +: ROW_W]           <= col_abs_n;
                    row_flag_q[int'(row_cnt_q)*TILE_SIZE*3 +: TILE_SIZE*3] <= row_flag_n;
                    col_flag_q[int'(row_cnt_q)*TILE_SIZE*3 +: TILE_SIZE*3] <= col_flag_n;
                    row_cost_q <= sat_add(row_cost_q, row_sum_n);
                    col_cost_q <= sat_add(col_cost_q, col_sum_n);
                    if (!last_row) row_cnt_q <= row_cnt_q + 1'b1;
                end
                DONE: begin
                    // First DONE cycle settles the direction choice, then raises o_valid.
                    if (!valid_q) begin
                        sel_col_q <= (col_cost_q < row_cost_q);
                        valid_q   <= 1'b1;
                    end else if (o_ready) begin
                        valid_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
